// File: rtl/alu_l2_pkg.sv
// Shared micro-architecture definitions for the ALU writeback pipeline:
// uop encodings, datapath widths and a small trace helper.
package alu_l2_pkg;

    // Encodings not listed here (e.g. UopIll) are treated as unsupported.
    typedef enum logic [3:0] {
        UopAdd  = 4'h0,
        UopSub  = 4'h1,
        UopAnd  = 4'h2,
        UopOr   = 4'h3,
        UopXor  = 4'h4,
        UopSlt  = 4'h5,
        UopSltu = 4'h6,
        UopLui  = 4'h7,
        UopSll  = 4'h8,
        UopSrl  = 4'h9,
        UopSra  = 4'hA,
        UopIll  = 4'hF
    } rv_uop_e;

    localparam int unsigned XlenW    = 32;
    localparam int unsigned RegAddrW = 5;
    // Trace characters per stage: valid, ':', two hex digits of seq_num.
    localparam int unsigned TraceCharsPerStage = 4;

    // ASCII lower-case hex digit for a nibble.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

endpackage

// File: rtl/alu_l2_if.sv
// Issue (D) and writeback (W) val/rdy channels of the ALU pipeline.
// master = issuing/consuming side, slave = the ALU.
interface alu_l2_if #(
    parameter int unsigned p_seq_num_bits = 5
);
    import alu_l2_pkg::*;

    // Issue channel
    logic                      d_val;
    logic                      d_rdy;
    logic [31:0]               d_pc;
    logic [p_seq_num_bits-1:0] d_seq_num;
    logic [XlenW-1:0]          d_op1;
    logic [XlenW-1:0]          d_op2;
    logic [RegAddrW-1:0]       d_waddr;
    rv_uop_e                   d_uop;

    // Writeback channel
    logic                      w_val;
    logic                      w_rdy;
    logic [31:0]               w_pc;
    logic [p_seq_num_bits-1:0] w_seq_num;
    logic [RegAddrW-1:0]       w_waddr;
    logic [XlenW-1:0]          w_wdata;
    logic                      w_wen;

    modport master (
        output d_val, d_pc, d_seq_num, d_op1, d_op2, d_waddr, d_uop, w_rdy,
        input  d_rdy, w_val, w_pc, w_seq_num, w_waddr, w_wdata, w_wen
    );

    modport slave (
        input  d_val, d_pc, d_seq_num, d_op1, d_op2, d_waddr, d_uop, w_rdy,
        output d_rdy, w_val, w_pc, w_seq_num, w_waddr, w_wdata, w_wen
    );

endinterface

// File: rtl/alu_l2_stage.sv
// One val/rdy pipeline register. Accepts when empty or when the downstream
// stage takes the current entry in the same cycle.
module alu_l2_stage #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_val_i,
    output logic             in_rdy_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_val_o,
    input  logic             out_rdy_i,
    output logic [Width-1:0] out_data_o
);

    logic             val_d, val_q;
    logic [Width-1:0] data_q;

    assign in_rdy_o   = !val_q || out_rdy_i;
    assign out_val_o  = val_q;
    assign out_data_o = data_q;

    // Next valid: reload from upstream whenever this slot is free or draining.
    always_comb begin
        val_d = val_q;
        if (in_rdy_o) begin
            val_d = in_val_i;
        end
    end

    // Valid bit is the only reset state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= 1'b0;
        end else begin
            val_q <= val_d;
        end
    end

    // Payload captured on an actual transfer only.
    always_ff @(posedge clk) begin
        if (in_val_i && in_rdy_o) begin
            data_q <= in_data_i;
        end
    end

endmodule

// File: rtl/alu_l2.sv
// Pipelined single-cycle-compute ALU with val/rdy issue and writeback.
// Result is computed from the issue fields and carried through
// p_num_stages registers. Define ALU_L2_SHIFT_EN to add SLL/SRL/SRA.
module alu_l2
    import alu_l2_pkg::*;
#(
    parameter int unsigned p_seq_num_bits = 5,
    parameter int unsigned p_num_stages   = 2
) (
    input logic     clk,
    input logic     rst,
    alu_l2_if.slave alu_io
);

    localparam int unsigned PayloadW = 32 + p_seq_num_bits + RegAddrW + XlenW + 1;
    localparam int unsigned TraceW   = 8 * TraceCharsPerStage * p_num_stages;

    logic [XlenW-1:0]    result;
    logic                supported;
    logic                wen;
    logic [PayloadW-1:0] d_word;
    logic [PayloadW-1:0] last_data;
    logic [TraceW-1:0]   trace_vec;

    // Combinational execute on the issue-channel operands.
    always_comb begin
        result    = '0;
        supported = 1'b1;
        case (alu_io.d_uop)
            UopAdd:  result = alu_io.d_op1 + alu_io.d_op2;
            UopSub:  result = alu_io.d_op1 - alu_io.d_op2;
            UopAnd:  result = alu_io.d_op1 & alu_io.d_op2;
            UopOr:   result = alu_io.d_op1 | alu_io.d_op2;
            UopXor:  result = alu_io.d_op1 ^ alu_io.d_op2;
            UopSlt:  result = {31'b0, $signed(alu_io.d_op1) < $signed(alu_io.d_op2)};
            UopSltu: result = {31'b0, alu_io.d_op1 < alu_io.d_op2};
            UopLui:  result = alu_io.d_op2;
`ifdef ALU_L2_SHIFT_EN
            UopSll:  result = alu_io.d_op1 << alu_io.d_op2[4:0];
            UopSrl:  result = alu_io.d_op1 >> alu_io.d_op2[4:0];
            UopSra:  result = $unsigned($signed(alu_io.d_op1) >>> alu_io.d_op2[4:0]);
`endif
            default: begin
                result    = '0;
                supported = 1'b0;
            end
        endcase
    end

    assign wen    = supported && (alu_io.d_waddr != '0);
    assign d_word = {alu_io.d_pc, alu_io.d_seq_num, alu_io.d_waddr, result, wen};

    // Stage k feeds stage k+1; rdy ripples back from W.rdy through each stage.
    for (genvar k = 0; k < p_num_stages; k++) begin : g_stage
        logic                in_val;
        logic                in_rdy;
        logic [PayloadW-1:0] in_data;
        logic                out_val;
        logic                out_rdy;
        logic [PayloadW-1:0] out_data;
        logic [7:0]          seq8;

        if (k == 0) begin : g_first
            assign in_val  = alu_io.d_val;
            assign in_data = d_word;
        end else begin : g_chain
            assign in_val  = g_stage[k-1].out_val;
            assign in_data = g_stage[k-1].out_data;
        end

        if (k == p_num_stages - 1) begin : g_last
            assign out_rdy = alu_io.w_rdy;
        end else begin : g_inner
            assign out_rdy = g_stage[k+1].in_rdy;
        end

        alu_l2_stage #(
            .Width(PayloadW)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_val_i  (in_val),
            .in_rdy_o  (in_rdy),
            .in_data_i (in_data),
            .out_val_o (out_val),
            .out_rdy_i (out_rdy),
            .out_data_o(out_data)
        );

        // Stage 0 occupies the leftmost trace characters.
        assign seq8 = 8'(out_data[PayloadW-33 -: p_seq_num_bits]);
        assign trace_vec[(p_num_stages-1-k)*32 +: 32] =
            {(out_val ? 8'h31 : 8'h30), 8'h3A, hex_char(seq8[7:4]), hex_char(seq8[3:0])};
    end

    assign alu_io.d_rdy = g_stage[0].in_rdy;
    assign alu_io.w_val = g_stage[p_num_stages-1].out_val;
    assign last_data    = g_stage[p_num_stages-1].out_data;
    assign {alu_io.w_pc, alu_io.w_seq_num, alu_io.w_waddr, alu_io.w_wdata, alu_io.w_wen} =
        last_data;

    // Fixed-width "v:ss" per stage, stage 0 first.
    function automatic logic [TraceW-1:0] trace();
        return trace_vec;
    endfunction

endmodule
